// File: rtl/cache_block_filler.sv
// cache_block_filler: packs an element stream into blocks and writes them to SRAM.
// Define CACHE_FILLER_VERIFY_EN to read back and compare every written block.
module cache_block_filler #(
   parameter int ELEMENT_WIDTH      = 32,
   parameter int ELEMENTS_PER_BLOCK = 4,
   parameter int LG_EPB             = 2,
   parameter int WIDTH              = 128,
   parameter int LG_DEPTH           = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [LG_DEPTH-1:0]      cmd_base,
   input  logic [LG_DEPTH:0]        cmd_blocks,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ELEMENT_WIDTH-1:0] in_data,
   input  logic                     in_last,
   output logic                     ram_en,
   output logic                     ram_we,
   output logic [LG_DEPTH-1:0]      ram_addr,
   output logic [WIDTH-1:0]         ram_din,
   input  logic [WIDTH-1:0]         ram_dout,
   output logic                     done,
   output logic                     err_short,
   output logic                     err_verify
);

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      WRITE,
`ifdef CACHE_FILLER_VERIFY_EN
      RDBK,
      CHECK,
`endif
      DONE
   } state_t;

   localparam logic [LG_EPB-1:0] LAST_IDX =
      LG_EPB'(ELEMENTS_PER_BLOCK - 1);
   localparam logic [LG_DEPTH:0] ONE_BLK =
      (LG_DEPTH + 1)'(1);

   state_t              state;
   logic [LG_DEPTH-1:0] addr;
   logic [LG_DEPTH:0]   remaining;
   logic [LG_EPB-1:0]   idx;
   logic [WIDTH-1:0]    shadow;
   logic [WIDTH-1:0]    shadow_nx;
   logic                ended;
   logic                full;
   logic                last_blk;
   logic                step;

   assign full     = (idx == LAST_IDX);
   assign last_blk = (remaining == ONE_BLK);

`ifdef CACHE_FILLER_VERIFY_EN
   assign step = (state == CHECK);
`else
   assign step = (state == WRITE);
   logic unused_dout;
   assign unused_dout = ^ram_dout;
`endif

   // element k lands in slot k, element 0 least significant
   always_comb begin
      shadow_nx = shadow;
      for (int k = 0; k < ELEMENTS_PER_BLOCK; k++) begin
         if (idx == LG_EPB'(k))
            shadow_nx[k*ELEMENT_WIDTH +: ELEMENT_WIDTH] = in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         addr       <= '0;
         remaining  <= '0;
         idx        <= '0;
         shadow     <= '0;
         ended      <= 1'b0;
         cmd_ready  <= 1'b1;
         in_ready   <= 1'b0;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_din    <= '0;
         done       <= 1'b0;
         err_short  <= 1'b0;
         err_verify <= 1'b0;
      end else begin
         done   <= 1'b0;
         ram_en <= 1'b0;
         ram_we <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  addr       <= cmd_base;
                  remaining  <= cmd_blocks;
                  idx        <= '0;
                  shadow     <= '0;
                  ended      <= 1'b0;
                  err_short  <= 1'b0;
                  err_verify <= 1'b0;
                  cmd_ready  <= 1'b0;
                  if (cmd_blocks == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= FILL;
                     in_ready <= 1'b1;
                  end
               end
            end
            FILL: begin
               if (in_valid) begin
                  shadow <= shadow_nx;
                  idx    <= idx + 1'b1;
                  if (in_last && !(last_blk && full))
                     err_short <= 1'b1;
                  if (in_last || full) begin
                     ended    <= in_last;
                     state    <= WRITE;
                     in_ready <= 1'b0;
                     ram_en   <= 1'b1;
                     ram_we   <= 1'b1;
                     ram_addr <= addr;
                     ram_din  <= shadow_nx;
                  end
               end
            end
            WRITE: begin
`ifdef CACHE_FILLER_VERIFY_EN
               state  <= RDBK;
               ram_en <= 1'b1;
`endif
            end
`ifdef CACHE_FILLER_VERIFY_EN
            RDBK: state <= CHECK;
            CHECK: begin
               if (ram_dout != shadow)
                  err_verify <= 1'b1;
            end
`endif
            DONE: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase

         // block committed: advance, then finish or refill
         if (step) begin
            remaining <= remaining - 1'b1;
            addr      <= addr + 1'b1;
            if (last_blk || ended) begin
               state <= DONE;
               done  <= 1'b1;
            end else begin
               state    <= FILL;
               in_ready <= 1'b1;
               shadow   <= '0;
               idx      <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cache_block_filler.sv
// tb_cache_block_filler: scoreboard bench for cache_block_filler.
// Expected SRAM writes are queued at stimulus time and popped on ram_we.
module tb_cache_block_filler;

   localparam int EW  = 32;
   localparam int EPB = 4;
   localparam int W   = 128;
   localparam int LGD = 6;
`ifdef CACHE_FILLER_VERIFY_EN
   localparam int BLK_CYC = EPB + 3;
`else
   localparam int BLK_CYC = EPB + 1;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           cmd_valid = 1'b0;
   logic           cmd_ready;
   logic [LGD-1:0] cmd_base = '0;
   logic [LGD:0]   cmd_blocks = '0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [EW-1:0]  in_data = '0;
   logic           in_last = 1'b0;
   logic           ram_en;
   logic           ram_we;
   logic [LGD-1:0] ram_addr;
   logic [W-1:0]   ram_din;
   logic [W-1:0]   ram_dout = '0;
   logic           done;
   logic           err_short;
   logic           err_verify;

   cache_block_filler #(
      .ELEMENT_WIDTH(EW), .ELEMENTS_PER_BLOCK(EPB), .LG_EPB(2),
      .WIDTH(W), .LG_DEPTH(LGD)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_base(cmd_base), .cmd_blocks(cmd_blocks),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last),
      .ram_en(ram_en), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
      .done(done), .err_short(err_short), .err_verify(err_verify)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [LGD-1:0] addr;
      logic [W-1:0]   data;
   } wr_t;

   wr_t          exp_q[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           ram_en_cnt = 0;
   logic         corrupt = 1'b0;
   logic [W-1:0] mem [64];

   task automatic check(input string tag, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model, registered read; optional bit-0 corruption on readback
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_din;
         else ram_dout <= mem[ram_addr] ^ {{(W-1){1'b0}}, corrupt};
      end
   end

   always @(negedge clk) begin : mon
      wr_t e;
      if (ram_en) ram_en_cnt++;
      if (ram_en && ram_we) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {{(W-LGD){1'b0}}, ram_addr}, '1);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", {{(W-LGD){1'b0}}, ram_addr}, {{(W-LGD){1'b0}}, e.addr});
            check("wr_data", ram_din, e.data);
         end
      end
   end

   task automatic check_reset_outs();
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_in_ready", in_ready, 0);
      check("rst_ram_en", ram_en, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_din", ram_din, 0);
      check("rst_done", done, 0);
      check("rst_err_short", err_short, 0);
      check("rst_err_verify", err_verify, 0);
   endtask

   // called at a negedge; returns at a negedge
   task automatic run_cmd(input int base, input int blocks, input int n,
                          input int seed, input bit stall, input bit bad,
                          input int exp_lat);
      logic [W-1:0] blk;
      wr_t w;
      int  e, i, g, acc, en0;
      bit  rdy;
      e = 0;
      for (int b = 0; b < blocks && e < n; b++) begin
         blk = '0;
         for (int k = 0; k < EPB && e < n; k++) begin
            blk[k*EW +: EW] = EW'(seed + e + 1);
            e++;
         end
         w.addr = LGD'(base + b);
         w.data = blk;
         exp_q.push_back(w);
      end
      corrupt = bad;
      g = 0;
      while (!cmd_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      check("cmd_ready_wait", cmd_ready, 1);
      cmd_base = LGD'(base);
      cmd_blocks = (LGD+1)'(blocks);
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      acc = cyc;
      en0 = ram_en_cnt;
      check("in_ready_after_cmd", in_ready, (blocks != 0));
      check("err_verify_cleared", err_verify, 0);
      i = 0;
      g = 0;
      while (i < n && g < 400) begin
         in_valid = stall ? ($urandom_range(2) != 0) : 1'b1;
         in_data = EW'(seed + i + 1);
         in_last = (i == n - 1);
         rdy = in_ready;
         @(negedge clk);
         if (rdy && in_valid) i++;
         g++;
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      check("elements_taken", i, n);
      g = 0;
      while (!done && g < 200) begin
         @(negedge clk);
         g++;
      end
      check("done_seen", done, 1);
      if (exp_lat >= 0) check("latency", cyc - acc, exp_lat);
      check("err_short", err_short, (n < blocks * EPB));
      check("err_verify", err_verify, bad);
      check("writes_left", exp_q.size(), 0);
      if (blocks == 0) check("no_ram_access", ram_en_cnt - en0, 0);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("cmd_ready_back", cmd_ready, 1);
   endtask

   initial begin
      int en0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outs();

      run_cmd(5, 2, 8, 0, 1'b0, 1'b0, 2 * BLK_CYC);
      run_cmd(63, 2, 8, 32'h10, 1'b0, 1'b0, 2 * BLK_CYC);
      run_cmd(0, 3, 6, 0, 1'b0, 1'b0, -1);
      run_cmd(9, 0, 0, 0, 1'b0, 1'b0, 0);
      run_cmd(20, 3, 12, 32'h40, 1'b1, 1'b0, -1);

      // abort a fill after two elements
      cmd_base = 6'd10;
      cmd_blocks = 7'd1;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      in_valid = 1'b1;
      in_data = 32'hAA;
      @(negedge clk);
      in_data = 32'hBB;
      @(negedge clk);
      in_valid = 1'b0;
      en0 = ram_en_cnt;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outs();
      check("rst_no_write", ram_en_cnt - en0, 0);
      run_cmd(10, 1, 4, 32'h100, 1'b0, 1'b0, BLK_CYC);

`ifdef CACHE_FILLER_VERIFY_EN
      run_cmd(30, 1, 4, 32'h200, 1'b0, 1'b1, BLK_CYC);
      repeat (3) @(negedge clk);
      check("err_verify_sticky", err_verify, 1);
      run_cmd(31, 1, 4, 32'h300, 1'b0, 1'b0, BLK_CYC);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
